// File: rtl/uartrx_rcu.sv
// UART receive control unit: mid-bit sampling of start/data/(parity)/stop, byte buffer, status.
// Latency: outputs update one cycle after the stop-bit sample (stop at T+H+(DATA_BITS+1+P)*N).
// Backpressure: none; an unread byte is overwritten by the next good frame and flagged as overrun.
// Optional even-parity bit is compiled in with `define UARTRX_PARITY_EN.
module uartrx_rcu #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_bit_detected,
    input  logic                 serial_sync,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 parity_error
);

    localparam int TW  = $clog2(CLKS_PER_BIT) + 1;
    localparam int BCW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0]  T_HALF   = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0]  T_FULL   = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0]  T_ONE    = TW'(1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UARTRX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [TW-1:0]        timer;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    // The timer is loaded with the full count and the sample point is the cycle it reads 1,
    // so a load of H puts the first sample exactly H cycles after the start pulse.
    logic tick;
    logic start_ok;
    logic stop_smp;
    logic par_bad;
    logic do_load;

    assign tick     = (timer == T_ONE);
    assign start_ok = (state == S_START) && tick && !serial_sync;
    assign stop_smp = (state == S_STOP) && tick;
    assign do_load  = stop_smp && serial_sync && !par_bad;

`ifdef UARTRX_PARITY_EN
    logic par_bit;
    assign par_bad = ^{shift_reg, par_bit};
`else
    assign par_bad = 1'b0;
`endif

    // Frame sequencer: bit-period timer, bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UARTRX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_bit_detected) begin
                        state <= S_START;
                        timer <= T_HALF;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (serial_sync) begin
                            state <= S_IDLE;
                            timer <= '0;
                        end else begin
                            state   <= S_DATA;
                            timer   <= T_FULL;
                            bit_cnt <= '0;
                        end
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_reg <= {serial_sync, shift_reg[DATA_BITS-1:1]};
                        timer     <= T_FULL;
                        bit_cnt   <= bit_cnt + BCW'(1);
                        if (bit_cnt == LAST_BIT) begin
`ifdef UARTRX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
`ifdef UARTRX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        par_bit <= serial_sync;
                        timer   <= T_FULL;
                        state   <= S_STOP;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Output buffer and status; a load in the same cycle as data_read keeps the byte ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            if (start_ok) begin
                framing_error <= 1'b0;
            end
            if (stop_smp && !serial_sync) begin
                framing_error <= 1'b1;
            end
            if (do_load) begin
                rx_data       <= shift_reg;
                data_ready    <= 1'b1;
                overrun_error <= !data_read && (overrun_error || data_ready);
            end
        end
    end

`ifdef UARTRX_PARITY_EN
    // Parity status: cleared by a valid start bit, set by a good-stop frame with odd parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_error <= 1'b0;
        end else if (start_ok) begin
            parity_error <= 1'b0;
        end else if (stop_smp && serial_sync && par_bad) begin
            parity_error <= 1'b1;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uartrx_rcu.sv
// Bench for uartrx_rcu: drives whole UART frames bit-by-bit and compares outputs
// against a frame-level reference model of the receiver's status rules.
// Directed scenarios first, then randomized frames with random reads and stray start pulses.
module tb_uartrx_rcu;

    localparam int N  = 10;
    localparam int DB = 8;
    localparam int H  = N / 2;
`ifdef UARTRX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // One frame from start pulse up to and including the stop-sample cycle.
    localparam int FLEN = H + (DB + 1 + P) * N + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sbd = 1'b0;
    logic          ser = 1'b1;
    logic          rd  = 1'b0;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          framing_error;
    logic          overrun_error;
    logic          parity_error;

    uartrx_rcu #(.CLKS_PER_BIT(N), .DATA_BITS(DB)) dut (
        .clk                (clk),
        .rst                (rst),
        .start_bit_detected (sbd),
        .serial_sync        (ser),
        .data_read          (rd),
        .rx_data            (rx_data),
        .data_ready         (data_ready),
        .framing_error      (framing_error),
        .overrun_error      (overrun_error),
        .parity_error       (parity_error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [DB-1:0] m_data  = '0;
    logic          m_ready = 1'b0;
    logic          m_fe    = 1'b0;
    logic          m_oe    = 1'b0;
    logic          m_pe    = 1'b0;

    function automatic logic [DB+3:0] obs();
        return {rx_data, data_ready, framing_error, overrun_error, parity_error};
    endfunction

    function automatic logic [DB+3:0] expv();
        return {m_data, m_ready, m_fe, m_oe, m_pe};
    endfunction

    // Serial line level j cycles after the start pulse: each bit owns N cycles.
    function automatic logic line_at(input logic [DB-1:0] d, input logic stop,
                                     input logic par, input int j);
        int k;
        k = j / N;
        if (k == 0) return 1'b0;
        if (k <= DB) return d[k-1];
        if (P == 1 && k == DB + 1) return par;
        return stop;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par,
                              input logic rd_at_load, input logic spur,
                              output logic ready_pre);
        ready_pre = 1'b0;
        for (int j = 0; j < FLEN; j++) begin
            ser = line_at(d, stop, par, j);
            sbd = (j == 0) || (spur && j == 3 * N);
            rd  = rd_at_load && (j == FLEN - 1);
            step();
            if (j == FLEN - 2) ready_pre = data_ready;
        end
        sbd = 1'b0;
        rd  = 1'b0;
        ser = 1'b1;
        // Model: valid start clears errors; stop/parity decide accept or flag.
        m_fe = 1'b0;
        m_pe = 1'b0;
        if (!stop) begin
            m_fe = 1'b1;
            if (rd_at_load) begin m_ready = 1'b0; m_oe = 1'b0; end
        end else if (P == 1 && (($countones(d) + int'(par)) % 2 != 0)) begin
            m_pe = 1'b1;
            if (rd_at_load) begin m_ready = 1'b0; m_oe = 1'b0; end
        end else begin
            m_data  = d;
            m_oe    = !rd_at_load && (m_oe || m_ready);
            m_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n, input int rd_at);
        for (int i = 0; i < n; i++) begin
            rd = (i == rd_at);
            step();
        end
        rd = 1'b0;
        if (rd_at >= 0 && rd_at < n) begin
            m_ready = 1'b0;
            m_oe    = 1'b0;
        end
    endtask

    function automatic logic even_par(input logic [DB-1:0] d);
        return ($countones(d) % 2) != 0;
    endfunction

    task automatic test_reset();
        step();
        step();
        n_total++;
        if (obs() !== expv()) $display("FAIL reset_held obs=%h exp=%h", obs(), expv());
        else n_pass++;
        rst = 1'b0;
        idle(5, -1);
        n_total++;
        if (obs() !== expv()) $display("FAIL reset_idle obs=%h exp=%h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_basic();
        logic pre;
        send_frame(8'hA5, 1'b1, even_par(8'hA5), 1'b0, 1'b0, pre);
        n_total++;
        if (pre !== 1'b0) $display("FAIL basic_ready_early obs=%b exp=0", pre);
        else n_pass++;
        n_total++;
        if (obs() !== expv()) $display("FAIL basic_frame obs=%h exp=%h", obs(), expv());
        else n_pass++;
        idle(3, 0);
        n_total++;
        if (obs() !== expv()) $display("FAIL basic_read obs=%h exp=%h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_false_start();
        logic pre;
        for (int j = 0; j < 7; j++) begin
            ser = (j < 3) ? 1'b0 : 1'b1;
            sbd = (j == 0);
            step();
        end
        sbd = 1'b0;
        ser = 1'b1;
        n_total++;
        if (obs() !== expv()) $display("FAIL false_start_status obs=%h exp=%h", obs(), expv());
        else n_pass++;
        send_frame(8'h3C, 1'b1, even_par(8'h3C), 1'b0, 1'b0, pre);
        n_total++;
        if (obs() !== expv()) $display("FAIL false_start_next obs=%h exp=%h", obs(), expv());
        else n_pass++;
        idle(2, 0);
    endtask

    task automatic test_framing();
        logic pre;
        send_frame(8'h55, 1'b0, even_par(8'h55), 1'b0, 1'b0, pre);
        n_total++;
        if (obs() !== expv()) $display("FAIL framing_set obs=%h exp=%h", obs(), expv());
        else n_pass++;
        send_frame(8'h12, 1'b1, even_par(8'h12), 1'b0, 1'b0, pre);
        n_total++;
        if (obs() !== expv()) $display("FAIL framing_clear obs=%h exp=%h", obs(), expv());
        else n_pass++;
        idle(2, 0);
    endtask

    task automatic test_back_to_back_overrun();
        logic pre;
        send_frame(8'h11, 1'b1, even_par(8'h11), 1'b0, 1'b0, pre);
        send_frame(8'h22, 1'b1, even_par(8'h22), 1'b0, 1'b0, pre);
        n_total++;
        if (obs() !== expv()) $display("FAIL overrun_set obs=%h exp=%h", obs(), expv());
        else n_pass++;
        idle(3, 0);
        n_total++;
        if (obs() !== expv()) $display("FAIL overrun_read obs=%h exp=%h", obs(), expv());
        else n_pass++;
        send_frame(8'h33, 1'b1, even_par(8'h33), 1'b0, 1'b0, pre);
        send_frame(8'h44, 1'b1, even_par(8'h44), 1'b1, 1'b0, pre);
        n_total++;
        if (pre !== 1'b1) $display("FAIL read_load_pre obs=%b exp=1", pre);
        else n_pass++;
        n_total++;
        if (obs() !== expv()) $display("FAIL read_with_load obs=%h exp=%h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        for (int j = 0; j < 40; j++) begin
            ser = line_at(8'h6B, 1'b1, even_par(8'h6B), j);
            sbd = (j == 0);
            step();
        end
        sbd = 1'b0;
        rst = 1'b1;
        #1;
        m_data = '0; m_ready = 1'b0; m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0;
        n_total++;
        if (obs() !== expv()) $display("FAIL reset_mid_async obs=%h exp=%h", obs(), expv());
        else n_pass++;
        step();
        rst = 1'b0;
        for (int j = 41; j < FLEN + 10; j++) begin
            ser = (j < FLEN) ? line_at(8'h6B, 1'b1, even_par(8'h6B), j) : 1'b1;
            step();
        end
        ser = 1'b1;
        n_total++;
        if (obs() !== expv()) $display("FAIL reset_mid_after obs=%h exp=%h", obs(), expv());
        else n_pass++;
    endtask

`ifdef UARTRX_PARITY_EN
    task automatic test_parity();
        logic pre;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, pre);
        n_total++;
        if (obs() !== expv()) $display("FAIL parity_good obs=%h exp=%h", obs(), expv());
        else n_pass++;
        idle(2, 0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, pre);
        n_total++;
        if (obs() !== expv()) $display("FAIL parity_bad obs=%h exp=%h", obs(), expv());
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [DB-1:0] d;
        logic          stop, par, rdl, spur, pre, exp_pre;
        for (int i = 0; i < 14; i++) begin
            d       = DB'($urandom);
            stop    = ($urandom_range(0, 4) != 0);
            par     = even_par(d) ^ (P == 1 && $urandom_range(0, 3) == 0);
            rdl     = ($urandom_range(0, 3) == 0);
            spur    = 1'($urandom_range(0, 1));
            exp_pre = m_ready;
            send_frame(d, stop, par, rdl, spur, pre);
            n_total++;
            if (pre !== exp_pre) $display("FAIL rand_pre_%0d obs=%b exp=%b", i, pre, exp_pre);
            else n_pass++;
            n_total++;
            if (obs() !== expv()) $display("FAIL rand_frame_%0d obs=%h exp=%h", i, obs(), expv());
            else n_pass++;
            if ($urandom_range(0, 1) == 1)
                idle($urandom_range(1, 5), ($urandom_range(0, 1) == 1) ? 0 : -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_back_to_back_overrun();
        test_reset_mid_frame();
`ifdef UARTRX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
